// File: rtl/vecfile_param.sv
// Parameterised vector register file: two combinational read ports, a masked
// parallel write port, a serial lane-by-lane loader and a whole-file clear sweep.
module vecfile_param #(
    parameter int NREG   = 16,
    parameter int NLANE  = 5,
    parameter int W      = 32,
    parameter int BYPASS = 1,
    localparam int AW    = (NREG  > 1) ? $clog2(NREG)  : 1,
    localparam int LW    = (NLANE > 1) ? $clog2(NLANE) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [NLANE-1:0]   wmask,
    input  logic [NLANE*W-1:0] wdata,
    input  logic [AW-1:0]      ra1,
    input  logic [AW-1:0]      ra2,
    output logic [NLANE*W-1:0] rd1,
    output logic [NLANE*W-1:0] rd2,
    input  logic               ld_start,
    input  logic [AW-1:0]      ld_vreg,
    input  logic               ld_valid,
    input  logic [W-1:0]       ld_data,
    output logic               ld_ready,
    input  logic               clr_start,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] CLEAR = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] target;
    logic [AW-1:0] sweep;
    logic [LW-1:0] lane;
    logic          done_q;
    logic [W-1:0]  mem [NREG][NLANE];

    logic pwrite;
    logic beat;
    logic last_beat;
    logic last_sweep;

    // The serial loader yields to a parallel write aimed at the same register,
    // so the two ports never collide on one lane.
    assign pwrite     = we && (state != CLEAR);
    assign ld_ready   = (state == LOAD) && !(we && (waddr == target));
    assign beat       = ld_valid && ld_ready;
    assign last_beat  = beat && (lane == LW'(NLANE - 1));
    assign last_sweep = (state == CLEAR) && (sweep == AW'(NREG - 1));
    assign busy       = (state != IDLE);
    assign done       = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            target <= '0;
            sweep  <= '0;
            lane   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_beat || last_sweep;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state <= CLEAR;
                        sweep <= '0;
                    end else if (ld_start) begin
                        state  <= LOAD;
                        target <= ld_vreg;
                        lane   <= '0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        lane <= lane + LW'(1);
                        if (last_beat)
                            state <= IDLE;
                    end
                end
                CLEAR: begin
                    sweep <= sweep + AW'(1);
                    if (last_sweep)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++)
                for (int l = 0; l < NLANE; l++)
                    mem[r][l] <= '0;
        end else begin
            if (pwrite)
                for (int l = 0; l < NLANE; l++)
                    if (wmask[l])
                        mem[waddr][l] <= wdata[l*W +: W];
            if (beat)
                mem[target][lane] <= ld_data;
            if (state == CLEAR)
                for (int l = 0; l < NLANE; l++)
                    mem[sweep][l] <= '0;
        end
    end

    // Forwarding is per lane: only masked lanes of a live write are replaced.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int l = 0; l < NLANE; l++) begin
            rd1[l*W +: W] = mem[ra1][l];
            rd2[l*W +: W] = mem[ra2][l];
            if ((BYPASS != 0) && pwrite && wmask[l]) begin
                if (waddr == ra1)
                    rd1[l*W +: W] = wdata[l*W +: W];
                if (waddr == ra2)
                    rd2[l*W +: W] = wdata[l*W +: W];
            end
        end
    end

endmodule

// File: tb/tb_vecfile_param.sv
// Directed bench for vecfile_param: one forwarding instance and one
// non-forwarding instance driven by identical stimulus.
module tb_vecfile_param;

    logic         clk, reset, we, ld_start, ld_valid, clr_start;
    logic [3:0]   waddr, ra1, ra2, ld_vreg;
    logic [4:0]   wmask;
    logic [159:0] wdata;
    logic [31:0]  ld_data;
    logic [159:0] rd1, rd2, rd1_n, rd2_n;
    logic         ld_ready, busy, done, ld_ready_n, busy_n, done_n;

    int checks = 0;
    int errors = 0;
    int busy_tot = 0;
    int done_tot = 0;
    int bs, ds;

    vecfile_param #(.NREG(16), .NLANE(5), .W(32), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wmask(wmask),
        .wdata(wdata), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .ld_start(ld_start), .ld_vreg(ld_vreg), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready), .clr_start(clr_start),
        .busy(busy), .done(done)
    );

    vecfile_param #(.NREG(16), .NLANE(5), .W(32), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wmask(wmask),
        .wdata(wdata), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
        .ld_start(ld_start), .ld_vreg(ld_vreg), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_ready(ld_ready_n), .clr_start(clr_start),
        .busy(busy_n), .done(done_n)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_tot++;
        if (done) done_tot++;
    end

    function automatic logic [159:0] pk(input logic [31:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clk = 0; reset = 0; we = 0; waddr = 0; wmask = 0; wdata = 0;
        ra1 = 0; ra2 = 0; ld_start = 0; ld_vreg = 0; ld_valid = 0;
        ld_data = 0; clr_start = 0;

        // reset state
        #2 reset = 1;
        #1;
        chk("rst_busy", 160'(busy), 0);
        chk("rst_done", 160'(done), 0);
        chk("rst_ld_ready", 160'(ld_ready), 0);
        repeat (2) @(negedge clk);
        reset = 0;
        for (int i = 0; i < 16; i++) begin
            ra1 = 4'(i);
            ra2 = 4'(15 - i);
            #1;
            chk("rst_rd1", rd1, 0);
            chk("rst_rd2", rd2, 0);
            chk("rst_rd1_nobyp", rd1_n, 0);
            @(negedge clk);
        end
        chk("rst_busy_after", 160'(busy), 0);

        // masked write with same-cycle forwarding
        we = 1; waddr = 3; wmask = 5'b10101; wdata = pk(1, 2, 3, 4, 5); ra1 = 3;
        #1;
        chk("byp_same", rd1, pk(1, 0, 3, 0, 5));
        chk("nobyp_same", rd1_n, 0);
        @(negedge clk);
        we = 0;
        #1;
        chk("byp_next", rd1, pk(1, 0, 3, 0, 5));
        chk("nobyp_next", rd1_n, pk(1, 0, 3, 0, 5));
        @(negedge clk);
        we = 1; wmask = 5'b00000; wdata = '1;
        #1;
        chk("mask0_same", rd1, pk(1, 0, 3, 0, 5));
        @(negedge clk);
        we = 0;
        #1;
        chk("mask0_after", rd1, pk(1, 0, 3, 0, 5));

        // serial load to reg 7: a ready-check cycle, then beats with one gap
        @(negedge clk);
        ld_start = 1; ld_vreg = 7;
        #1;
        chk("ld_start_busy", 160'(busy), 0);
        bs = busy_tot; ds = done_tot;
        @(negedge clk);
        ld_start = 0; ld_vreg = 0;
        #1;
        chk("ld_ready_first", 160'(ld_ready), 1);
        chk("ld_busy", 160'(busy), 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) begin
                ld_valid = 0;
            end else begin
                ld_valid = 1;
                ld_data = 32'hA0 + 32'((k > 2) ? k - 1 : k);
            end
        end
        @(negedge clk);
        ld_valid = 0; ra1 = 7;
        #1;
        chk("ld_done", 160'(done), 1);
        chk("ld_idle", 160'(busy), 0);
        chk("ld_busy_cycles", 160'(busy_tot - bs), 7);
        chk("ld_done_count", 160'(done_tot - ds), 1);
        chk("ld_data_reg7", rd1, pk(32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4));
        @(negedge clk);
        #1;
        chk("ld_done_single", 160'(done), 0);

        // load to reg 7 contending with parallel writes
        @(negedge clk);
        ld_start = 1; ld_vreg = 7;
        @(negedge clk);
        ld_start = 0;
        we = 1; waddr = 7; wmask = 5'b10000; wdata = pk(0, 0, 0, 0, 32'h77);
        ld_valid = 1; ld_data = 32'hB0;
        #1;
        chk("conflict_ready", 160'(ld_ready), 0);
        @(negedge clk);
        waddr = 2; wmask = 5'b11111; wdata = pk(21, 22, 23, 24, 25);
        #1;
        chk("other_ready", 160'(ld_ready), 1);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            we = 0;
            ld_data = 32'hB0 + 32'(k);
        end
        @(negedge clk);
        ld_valid = 0; ra1 = 7; ra2 = 2;
        #1;
        chk("cfl_done", 160'(done), 1);
        chk("cfl_reg7", rd1, pk(32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4));
        chk("cfl_reg2", rd2, pk(21, 22, 23, 24, 25));

        // clear sweep wins over a simultaneous load request
        @(negedge clk);
        we = 1; waddr = 0; wmask = 5'b11111; wdata = pk(32'h10, 32'h11, 32'h12, 32'h13, 32'h14);
        @(negedge clk);
        waddr = 15; wdata = pk(32'hF0, 32'hF1, 32'hF2, 32'hF3, 32'hF4);
        @(negedge clk);
        we = 0; clr_start = 1; ld_start = 1; ld_vreg = 5;
        #1;
        chk("clr_start_busy", 160'(busy), 0);
        bs = busy_tot; ds = done_tot;
        @(negedge clk);
        clr_start = 0; ld_start = 0;
        we = 1; waddr = 0; wmask = 5'b11111; wdata = '1; ra1 = 0;
        #1;
        chk("clr_busy", 160'(busy), 1);
        chk("clr_not_load", 160'(ld_ready), 0);
        chk("clr_no_bypass", rd1, pk(32'h10, 32'h11, 32'h12, 32'h13, 32'h14));
        repeat (15) @(negedge clk);
        @(negedge clk);
        we = 0;
        #1;
        chk("clr_done", 160'(done), 1);
        chk("clr_idle", 160'(busy), 0);
        chk("clr_busy_cycles", 160'(busy_tot - bs), 16);
        chk("clr_done_count", 160'(done_tot - ds), 1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ra1 = 4'(i);
            ra2 = 4'(15 - i);
            #1;
            chk("clr_rd1", rd1, 0);
            chk("clr_rd2_nobyp", rd2_n, 0);
        end

        // reset aborts a load after three beats
        @(negedge clk);
        we = 1; waddr = 7; wdata = pk(7, 7, 7, 7, 7);
        @(negedge clk);
        we = 0; ld_start = 1; ld_vreg = 9;
        ds = done_tot;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ld_start = 0; ld_valid = 1;
            ld_data = 32'hC0 + 32'(k);
        end
        @(negedge clk);
        ld_valid = 0; reset = 1;
        #1;
        chk("abort_busy", 160'(busy), 0);
        chk("abort_ready", 160'(ld_ready), 0);
        chk("abort_done", 160'(done), 0);
        @(negedge clk);
        reset = 0; ra1 = 9; ra2 = 7;
        #1;
        chk("abort_reg9", rd1, 0);
        chk("abort_reg7", rd2, 0);
        chk("abort_reg9_nobyp", rd1_n, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", 160'(done_tot - ds), 0);
        ld_start = 1; ld_vreg = 9;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ld_start = 0; ld_valid = 1;
            ld_data = 32'hD0 + 32'(k);
        end
        @(negedge clk);
        ld_valid = 0;
        #1;
        chk("fresh_done", 160'(done), 1);
        chk("fresh_reg9", rd1, pk(32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
